// File: rtl/pkg_tpu.sv
// Shared scalar-unit types: operand data word, register index, register count.
package pkg_tpu;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_SREGS = 64;
    localparam int unsigned SIDX_W    = $clog2(NUM_SREGS);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SIDX_W-1:0] index_t;

endpackage

// File: rtl/reg_read_s_rf.sv
// Scalar register file storage: one write port, three combinational read ports,
// and a clear port used by the post-reset sweep.
// Ports:
//   clock               - clock
//   clr_en/clr_idx      - write zero to clr_idx (takes priority over wr_en)
//   wr_en/wr_idx/wr_data - write port
//   rd_idx1..3          - read addresses
//   rd_data1_c..3_c     - combinational read data
module rf_3r1w_s
    import pkg_tpu::*;
#(
    parameter int unsigned NUM_REGS    = NUM_SREGS,
    parameter int unsigned WIDTH_INDEX = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   clr_en,
    input  logic [WIDTH_INDEX-1:0] clr_idx,
    input  logic                   wr_en,
    input  logic [WIDTH_INDEX-1:0] wr_idx,
    input  data_t                  wr_data,
    input  logic [WIDTH_INDEX-1:0] rd_idx1,
    input  logic [WIDTH_INDEX-1:0] rd_idx2,
    input  logic [WIDTH_INDEX-1:0] rd_idx3,
    output data_t                  rd_data1_c,
    output data_t                  rd_data2_c,
    output data_t                  rd_data3_c
);

    data_t mem [NUM_REGS];

    // Storage has no reset; the clear sweep initialises it after every reset.
    always_ff @(posedge clock) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data1_c = mem[rd_idx1];
    assign rd_data2_c = mem[rd_idx2];
    assign rd_data3_c = mem[rd_idx3];

endmodule

// File: rtl/reg_read_s.sv
// Scalar register-read stage: clears the register file after reset, then
// captures three operands (with same-cycle write-back forwarding) into one
// pipeline stage feeding the scalar operand network.
// Ports:
//   clock, reset (async, active-low)
//   I_Stall                      - hold all output registers
//   I_Req, I_Rd_En1..3, I_Src_Idx1..3 - operand read request
//   I_WB_Req, I_WB_Idx, I_WB_Data     - write-back port
//   O_Ready                      - clear sweep finished
//   O_Req, O_Src_Idx1..3, O_Src_Data1..3 - registered operands
module reg_read_s
    import pkg_tpu::*;
#(
    parameter int unsigned NUM_REGS    = NUM_SREGS,
    parameter bit          ZERO_REG    = 1'b1,
    parameter int unsigned WIDTH_INDEX = $clog2(NUM_REGS)
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   I_Stall,
    input  logic   I_Req,
    input  logic   I_Rd_En1,
    input  logic   I_Rd_En2,
    input  logic   I_Rd_En3,
    input  index_t I_Src_Idx1,
    input  index_t I_Src_Idx2,
    input  index_t I_Src_Idx3,
    input  logic   I_WB_Req,
    input  index_t I_WB_Idx,
    input  data_t  I_WB_Data,
    output logic   O_Ready,
    output logic   O_Req,
    output index_t O_Src_Idx1,
    output index_t O_Src_Idx2,
    output index_t O_Src_Idx3,
    output data_t  O_Src_Data1,
    output data_t  O_Src_Data2,
    output data_t  O_Src_Data3
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state, state_d;
    logic [WIDTH_INDEX-1:0] cnt, cnt_d;
    logic                   clr_en_c;
    logic                   wr_en_c;
    logic                   ready_d, req_d;

    logic   [2:0] rd_en;
    index_t       src_idx [3];
    data_t        rf_data [3];
    index_t       idx_d   [3];
    data_t        data_d  [3];
    index_t       o_idx   [3];
    data_t        o_data  [3];

    assign rd_en      = {I_Rd_En3, I_Rd_En2, I_Rd_En1};
    assign src_idx[0] = I_Src_Idx1;
    assign src_idx[1] = I_Src_Idx2;
    assign src_idx[2] = I_Src_Idx3;

    // Index 0 write drop keeps the zero register at zero.
    assign wr_en_c = (state == RUN) && I_WB_Req && !(ZERO_REG && (I_WB_Idx == '0));

    rf_3r1w_s #(
        .NUM_REGS    (NUM_REGS),
        .WIDTH_INDEX (WIDTH_INDEX)
    ) u_rf (
        .clock      (clock),
        .clr_en     (clr_en_c),
        .clr_idx    (cnt),
        .wr_en      (wr_en_c),
        .wr_idx     (I_WB_Idx),
        .wr_data    (I_WB_Data),
        .rd_idx1    (I_Src_Idx1),
        .rd_idx2    (I_Src_Idx2),
        .rd_idx3    (I_Src_Idx3),
        .rd_data1_c (rf_data[0]),
        .rd_data2_c (rf_data[1]),
        .rd_data3_c (rf_data[2])
    );

    // Operand select: disabled port, zero register, same-cycle write-back, array.
    function automatic data_t operand(input logic en, input index_t idx, input data_t rfd,
                                      input logic wb_req, input index_t wb_idx,
                                      input data_t wb_data);
        if (!en) begin
            return '0;
        end else if (ZERO_REG && (idx == '0)) begin
            return '0;
        end else if (wb_req && (wb_idx == idx)) begin
            return wb_data;
        end else begin
            return rfd;
        end
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        clr_en_c = 1'b0;
        ready_d  = O_Ready;
        req_d    = O_Req;
        for (int k = 0; k < 3; k++) begin
            idx_d[k]  = o_idx[k];
            data_d[k] = o_data[k];
        end

        case (state)
            INIT: begin
                clr_en_c = 1'b1;
                cnt_d    = cnt + WIDTH_INDEX'(1);
                if (cnt == WIDTH_INDEX'(NUM_REGS - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                ready_d = 1'b1;
                if (!I_Stall) begin
                    req_d = I_Req;
                    for (int k = 0; k < 3; k++) begin
                        if (I_Req && rd_en[k]) begin
                            idx_d[k]  = src_idx[k];
                            data_d[k] = operand(1'b1, src_idx[k], rf_data[k],
                                                I_WB_Req, I_WB_Idx, I_WB_Data);
                        end else begin
                            idx_d[k]  = '0;
                            data_d[k] = '0;
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, sweep counter and output stage registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            cnt     <= '0;
            O_Ready <= 1'b0;
            O_Req   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                o_idx[k]  <= '0;
                o_data[k] <= '0;
            end
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            O_Ready <= ready_d;
            O_Req   <= req_d;
            for (int k = 0; k < 3; k++) begin
                o_idx[k]  <= idx_d[k];
                o_data[k] <= data_d[k];
            end
        end
    end

    assign O_Src_Idx1  = o_idx[0];
    assign O_Src_Idx2  = o_idx[1];
    assign O_Src_Idx3  = o_idx[2];
    assign O_Src_Data1 = o_data[0];
    assign O_Src_Data2 = o_data[1];
    assign O_Src_Data3 = o_data[2];

endmodule

// File: tb/tb_reg_read_s.sv
// Directed testbench for reg_read_s (NUM_REGS=64, ZERO_REG=1).
module tb_reg_read_s;
    import pkg_tpu::*;

    logic   clock, reset;
    logic   I_Stall, I_Req, I_Rd_En1, I_Rd_En2, I_Rd_En3;
    index_t I_Src_Idx1, I_Src_Idx2, I_Src_Idx3;
    logic   I_WB_Req;
    index_t I_WB_Idx;
    data_t  I_WB_Data;
    logic   O_Ready, O_Req;
    index_t O_Src_Idx1, O_Src_Idx2, O_Src_Idx3;
    data_t  O_Src_Data1, O_Src_Data2, O_Src_Data3;

    int checks = 0;
    int errors = 0;

    reg_read_s dut (
        .clock       (clock),
        .reset       (reset),
        .I_Stall     (I_Stall),
        .I_Req       (I_Req),
        .I_Rd_En1    (I_Rd_En1),
        .I_Rd_En2    (I_Rd_En2),
        .I_Rd_En3    (I_Rd_En3),
        .I_Src_Idx1  (I_Src_Idx1),
        .I_Src_Idx2  (I_Src_Idx2),
        .I_Src_Idx3  (I_Src_Idx3),
        .I_WB_Req    (I_WB_Req),
        .I_WB_Idx    (I_WB_Idx),
        .I_WB_Data   (I_WB_Data),
        .O_Ready     (O_Ready),
        .O_Req       (O_Req),
        .O_Src_Idx1  (O_Src_Idx1),
        .O_Src_Idx2  (O_Src_Idx2),
        .O_Src_Idx3  (O_Src_Idx3),
        .O_Src_Data1 (O_Src_Data1),
        .O_Src_Data2 (O_Src_Data2),
        .O_Src_Data3 (O_Src_Data3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        I_Stall = 0; I_Req = 0;
        I_Rd_En1 = 0; I_Rd_En2 = 0; I_Rd_En3 = 0;
        I_Src_Idx1 = '0; I_Src_Idx2 = '0; I_Src_Idx3 = '0;
        I_WB_Req = 0; I_WB_Idx = '0; I_WB_Data = '0;
    endtask

    task automatic read3(input logic e1, input index_t i1, input logic e2, input index_t i2,
                         input logic e3, input index_t i3);
        I_Req = 1;
        I_Rd_En1 = e1; I_Src_Idx1 = i1;
        I_Rd_En2 = e2; I_Src_Idx2 = i2;
        I_Rd_En3 = e3; I_Src_Idx3 = i3;
    endtask

    task automatic write_wb(input index_t idx, input data_t d);
        I_WB_Req = 1; I_WB_Idx = idx; I_WB_Data = d;
    endtask

    // Sweep after reset release; I_Req/I_WB_Req must be ignored throughout.
    task automatic run_sweep(input string tag);
        @(negedge clock);
        reset = 1;
        read3(1, 6'd63, 1, 6'd63, 1, 6'd63);
        write_wb(6'd63, 32'h5555_5555);
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) idle_inputs();
            step();
            checks++;
            if (O_Ready !== (k >= 64)) begin
                errors++;
                $display("FAIL %s ready k=%0d: got %b expected %b", tag, k, O_Ready, (k >= 64));
            end
            checks++;
            if (O_Req !== 1'b0) begin
                errors++;
                $display("FAIL %s req_during_init k=%0d: got %b expected 0", tag, k, O_Req);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #3;
        checks++;
        if ({O_Ready, O_Req, O_Src_Idx1, O_Src_Idx2, O_Src_Idx3} !== '0 ||
            {O_Src_Data1, O_Src_Data2, O_Src_Data3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b req=%b d1=%h expected all zero", O_Ready, O_Req, O_Src_Data1);
        end
        repeat (2) step();
        run_sweep("init");
    endtask

    task automatic test_init_read();
        repeat (5) step();
        read3(1, 6'd5, 1, 6'd6, 1, 6'd7);
        step();
        idle_inputs();
        checks++;
        if (O_Req !== 1'b1 || O_Src_Idx1 !== 6'd5 || O_Src_Idx2 !== 6'd6 || O_Src_Idx3 !== 6'd7) begin
            errors++;
            $display("FAIL init_read_idx: req=%b idx=%0d/%0d/%0d expected 1 5/6/7", O_Req, O_Src_Idx1, O_Src_Idx2, O_Src_Idx3);
        end
        checks++;
        if ({O_Src_Data1, O_Src_Data2, O_Src_Data3} !== '0) begin
            errors++;
            $display("FAIL init_read_data: got %h/%h/%h expected 0/0/0", O_Src_Data1, O_Src_Data2, O_Src_Data3);
        end
        read3(1, 6'd63, 0, '0, 0, '0);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data1 !== 32'h0) begin
            errors++;
            $display("FAIL init_write_ignored: got %h expected 0", O_Src_Data1);
        end
    endtask

    task automatic test_write_read();
        write_wb(6'd5, 32'hDEAD_BEEF);
        step();
        idle_inputs();
        read3(1, 6'd5, 0, '0, 0, '0);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data1 !== 32'hDEAD_BEEF || O_Src_Idx1 !== 6'd5 || O_Req !== 1'b1) begin
            errors++;
            $display("FAIL write_read: data=%h idx=%0d req=%b expected deadbeef 5 1", O_Src_Data1, O_Src_Idx1, O_Req);
        end
        checks++;
        if (O_Src_Data2 !== 32'h0 || O_Src_Idx2 !== '0) begin
            errors++;
            $display("FAIL write_read_port2_off: data=%h idx=%0d expected 0 0", O_Src_Data2, O_Src_Idx2);
        end
    endtask

    task automatic test_forward();
        write_wb(6'd9, 32'h1234);
        read3(0, '0, 1, 6'd9, 0, '0);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data2 !== 32'h1234 || O_Src_Idx2 !== 6'd9) begin
            errors++;
            $display("FAIL forward: data=%h idx=%0d expected 1234 9", O_Src_Data2, O_Src_Idx2);
        end
        read3(0, '0, 0, '0, 1, 6'd9);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data3 !== 32'h1234) begin
            errors++;
            $display("FAIL forward_stored: got %h expected 1234", O_Src_Data3);
        end
    endtask

    task automatic test_zero_reg();
        write_wb(6'd0, 32'hFFFF_FFFF);
        step();
        idle_inputs();
        read3(1, 6'd0, 0, '0, 0, 6'd5);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data1 !== 32'h0 || O_Src_Idx1 !== 6'd0) begin
            errors++;
            $display("FAIL zero_reg_read: data=%h idx=%0d expected 0 0", O_Src_Data1, O_Src_Idx1);
        end
        checks++;
        if (O_Src_Data3 !== 32'h0 || O_Src_Idx3 !== 6'd0) begin
            errors++;
            $display("FAIL rd_en3_off: data=%h idx=%0d expected 0 0", O_Src_Data3, O_Src_Idx3);
        end
        write_wb(6'd0, 32'hFFFF_FFFF);
        read3(0, '0, 1, 6'd0, 0, '0);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_no_forward: got %h expected 0", O_Src_Data2);
        end
    endtask

    task automatic test_duplicates();
        read3(1, 6'd5, 1, 6'd5, 1, 6'd5);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data1 !== 32'hDEAD_BEEF || O_Src_Data2 !== 32'hDEAD_BEEF || O_Src_Data3 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL duplicates: got %h/%h/%h expected deadbeef x3", O_Src_Data1, O_Src_Data2, O_Src_Data3);
        end
    endtask

    task automatic test_idle();
        step();
        checks++;
        if (O_Req !== 1'b0 || O_Src_Data1 !== '0 || O_Src_Idx1 !== '0) begin
            errors++;
            $display("FAIL idle: req=%b data=%h idx=%0d expected 0 0 0", O_Req, O_Src_Data1, O_Src_Idx1);
        end
    endtask

    task automatic test_stall();
        write_wb(6'd4, 32'hA);
        step();
        idle_inputs();
        read3(1, 6'd4, 0, '0, 0, '0);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data1 !== 32'hA) begin
            errors++;
            $display("FAIL stall_capture: got %h expected a", O_Src_Data1);
        end
        I_Stall = 1;
        read3(1, 6'd5, 1, 6'd9, 0, '0);
        write_wb(6'd4, 32'hB);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (O_Src_Data1 !== 32'hA || O_Src_Idx1 !== 6'd4 || O_Req !== 1'b1 || O_Src_Data2 !== '0) begin
                errors++;
                $display("FAIL stall_hold c=%0d: data=%h idx=%0d req=%b d2=%h expected a 4 1 0",
                         c, O_Src_Data1, O_Src_Idx1, O_Req, O_Src_Data2);
            end
        end
        idle_inputs();
        read3(1, 6'd4, 0, '0, 0, '0);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data1 !== 32'hB) begin
            errors++;
            $display("FAIL stall_reread: got %h expected b", O_Src_Data1);
        end
    endtask

    task automatic test_back_to_back();
        read3(1, 6'd4, 0, '0, 0, '0);
        step();
        checks++;
        if (O_Src_Data1 !== 32'hB || O_Req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_0: data=%h req=%b expected b 1", O_Src_Data1, O_Req);
        end
        read3(0, '0, 1, 6'd5, 0, '0);
        step();
        checks++;
        if (O_Src_Data2 !== 32'hDEAD_BEEF || O_Src_Data1 !== '0 || O_Req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_1: d2=%h d1=%h req=%b expected deadbeef 0 1", O_Src_Data2, O_Src_Data1, O_Req);
        end
        read3(0, '0, 0, '0, 1, 6'd9);
        step();
        idle_inputs();
        checks++;
        if (O_Src_Data3 !== 32'h1234 || O_Src_Idx3 !== 6'd9 || O_Src_Data2 !== '0) begin
            errors++;
            $display("FAIL b2b_2: d3=%h idx3=%0d d2=%h expected 1234 9 0", O_Src_Data3, O_Src_Idx3, O_Src_Data2);
        end
    endtask

    task automatic test_mid_reset();
        read3(1, 6'd5, 1, 6'd9, 1, 6'd4);
        step();
        idle_inputs();
        checks++;
        if (O_Req !== 1'b1 || O_Src_Data1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mid_reset_pre: req=%b d1=%h expected 1 deadbeef", O_Req, O_Src_Data1);
        end
        #2;
        reset = 0;
        #1;
        checks++;
        if ({O_Ready, O_Req, O_Src_Idx1, O_Src_Idx2, O_Src_Idx3} !== '0 ||
            {O_Src_Data1, O_Src_Data2, O_Src_Data3} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: ready=%b req=%b d1=%h expected all zero", O_Ready, O_Req, O_Src_Data1);
        end
        run_sweep("reinit");
        read3(1, 6'd5, 1, 6'd9, 1, 6'd4);
        step();
        idle_inputs();
        checks++;
        if ({O_Src_Data1, O_Src_Data2, O_Src_Data3} !== '0 || O_Req !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_cleared: got %h/%h/%h req=%b expected 0/0/0 1",
                     O_Src_Data1, O_Src_Data2, O_Src_Data3, O_Req);
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_write_read();
        test_forward();
        test_zero_reg();
        test_duplicates();
        test_idle();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
